pong_renderer: RTL and testbench

Pixel-colour generator that consumes the game state produced by the Pong game logic and turns it into a 12-bit RGB stream for the VGA output stage. It sits between the VGA timing generator, which supplies `pixel_x`, `pixel_y` and `video_on`, and the DAC/pin drivers. Game state is snapshotted once per frame in vertical blanking to prevent tearing. Output is a 2-stage pipeline: geometry/hit flags, then glyph lookup and colour priority mux.

---
 rtl/pong_pkg.sv | 40 ++++
 rtl/score_glyph.sv | 26 ++
 rtl/pong_renderer.sv | 193 +++++++++++++++++++
 tb/tb_pong_renderer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong screen geometry, colour constants and rectangle/score helpers
// used by the renderer, the game logic and the timing generator.
package pong_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CMP_W   = 11;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned GLYPH_W = 15;
  localparam int unsigned FCNT_W  = 6;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned SQ_SIDE    = 16;
  localparam int unsigned PDL_THICK  = 12;
  localparam int unsigned PDL_TALL   = 96;
  localparam int unsigned GLYPH_CELL = 8;
  localparam int unsigned P1_DIG_X   = 256;
  localparam int unsigned P2_DIG_X   = 360;
  localparam int unsigned DIG_TOP    = 32;
  localparam int unsigned NET_X      = 318;
  localparam int unsigned NET_W      = 4;

  localparam logic [RGB_W-1:0] COL_BG   = 12'h000;
  localparam logic [RGB_W-1:0] COL_FG   = 12'hFFF;
  localparam logic [RGB_W-1:0] COL_NET  = 12'h888;
  localparam logic [RGB_W-1:0] COL_OVER = 12'hF00;

  // Half-open rectangle test; one extra bit keeps pos+size from wrapping.
  function automatic logic in_rect(input logic [CMP_W-1:0] x, input logic [CMP_W-1:0] y,
                                   input logic [CMP_W-1:0] rx, input logic [CMP_W-1:0] ry,
                                   input logic [CMP_W-1:0] w, input logic [CMP_W-1:0] h);
    return (x >= rx) && (x < CMP_W'(rx + w)) && (y >= ry) && (y < CMP_W'(ry + h));
  endfunction

  function automatic logic [SCORE_W-1:0] units_digit(input logic [SCORE_W-1:0] score);
    return (score < SCORE_W'(10)) ? score : SCORE_W'(score - SCORE_W'(10));
  endfunction

endpackage

// File: rtl/score_glyph.sv
// 3x5 digit font, row-major with the top-left cell in the MSB; 10..15 blank.
module score_glyph
  import pong_pkg::*;
(
  input  logic [SCORE_W-1:0] digit,
  output logic [GLYPH_W-1:0] font_c
);

  always_comb begin
    font_c = '0;
    case (digit)
      4'd0:    font_c = 15'b111_101_101_101_111;
      4'd1:    font_c = 15'b010_110_010_010_111;
      4'd2:    font_c = 15'b111_001_111_100_111;
      4'd3:    font_c = 15'b111_001_111_001_111;
      4'd4:    font_c = 15'b101_101_111_001_001;
      4'd5:    font_c = 15'b111_100_111_001_111;
      4'd6:    font_c = 15'b111_100_111_101_111;
      4'd7:    font_c = 15'b111_001_001_001_001;
      4'd8:    font_c = 15'b111_101_111_101_111;
      4'd9:    font_c = 15'b111_101_111_001_111;
      default: font_c = '0;
    endcase
  end

endmodule

// File: rtl/pong_renderer.sv
// Pong pixel-colour generator: per-frame game-state snapshot in vblank,
// then a two-stage geometry / glyph-and-priority pipeline to 12-bit RGB.
module pong_renderer
  import pong_pkg::*;
#(
  parameter int unsigned H_VIDEO    = SCREEN_W,
  parameter int unsigned V_VIDEO    = SCREEN_H,
  parameter int unsigned SQ_WIDTH   = SQ_SIDE,
  parameter int unsigned PDL_WIDTH  = PDL_THICK,
  parameter int unsigned PDL_HEIGHT = PDL_TALL,
  parameter int unsigned CELL       = GLYPH_CELL,
  parameter int unsigned P1_DIGIT_X = P1_DIG_X,
  parameter int unsigned P2_DIGIT_X = P2_DIG_X,
  parameter int unsigned DIGIT_Y    = DIG_TOP
) (
  input  logic                 clk_0,
  input  logic                 rst,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  input  logic                 video_on,
  input  logic [COORD_W-1:0]   sq_xpos,
  input  logic [COORD_W-1:0]   sq_ypos,
  input  logic [COORD_W-1:0]   pdl1_xpos,
  input  logic [COORD_W-1:0]   pdl1_ypos,
  input  logic [COORD_W-1:0]   pdl2_xpos,
  input  logic [COORD_W-1:0]   pdl2_ypos,
  input  logic                 sq_shown,
  input  logic                 game_over,
  input  logic                 game_startup,
  input  logic [SCORE_W-1:0]   score_p1,
  input  logic [SCORE_W-1:0]   score_p2,
  output logic [RGB_W-1:0]     pixel_rgb,
  output logic                 frame_tick
);

  localparam int unsigned CELL_SH = $clog2(CELL);
  localparam logic [CMP_W-1:0] SQ_SZ  = CMP_W'(SQ_WIDTH);
  localparam logic [CMP_W-1:0] PDL_W  = CMP_W'(PDL_WIDTH);
  localparam logic [CMP_W-1:0] PDL_H  = CMP_W'(PDL_HEIGHT);
  localparam logic [CMP_W-1:0] BOX_W  = CMP_W'(3 * CELL);
  localparam logic [CMP_W-1:0] BOX_H  = CMP_W'(5 * CELL);
  localparam logic [CMP_W-1:0] DIG_Y  = CMP_W'(DIGIT_Y);
  localparam logic [CMP_W-1:0] P1_UX  = CMP_W'(P1_DIGIT_X);
  localparam logic [CMP_W-1:0] P1_TX  = CMP_W'(P1_DIGIT_X - 4 * CELL);
  localparam logic [CMP_W-1:0] P2_UX  = CMP_W'(P2_DIGIT_X);
  localparam logic [CMP_W-1:0] P2_TX  = CMP_W'(P2_DIGIT_X - 4 * CELL);
  localparam logic [CMP_W-1:0] NET_X0 = CMP_W'(NET_X);
  localparam logic [CMP_W-1:0] NET_X1 = CMP_W'(NET_X + NET_W);
  localparam logic [CMP_W-1:0] H_LIM  = CMP_W'(H_VIDEO);
  localparam logic [CMP_W-1:0] V_LIM  = CMP_W'(V_VIDEO);

  logic [COORD_W-1:0] sh_sq_x, sh_sq_y, sh_p1_x, sh_p1_y, sh_p2_x, sh_p2_y;
  logic               sh_shown, sh_over, sh_startup, snap_seen;
  logic [SCORE_W-1:0] sh_s1, sh_s2;
  logic [FCNT_W-1:0]  frame_cnt;
  logic               snap_c;

  assign snap_c = (pixel_x == '0) && (pixel_y == COORD_W'(V_VIDEO));

  // Shadow game state; snap_seen blanks the screen until the first snapshot.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      sh_sq_x    <= '0;
      sh_sq_y    <= '0;
      sh_p1_x    <= '0;
      sh_p1_y    <= '0;
      sh_p2_x    <= '0;
      sh_p2_y    <= '0;
      sh_s1      <= '0;
      sh_s2      <= '0;
      sh_shown   <= 1'b0;
      sh_over    <= 1'b0;
      sh_startup <= 1'b1;
      snap_seen  <= 1'b0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= snap_c;
      if (snap_c) begin
        sh_sq_x    <= sq_xpos;
        sh_sq_y    <= sq_ypos;
        sh_p1_x    <= pdl1_xpos;
        sh_p1_y    <= pdl1_ypos;
        sh_p2_x    <= pdl2_xpos;
        sh_p2_y    <= pdl2_ypos;
        sh_s1      <= score_p1;
        sh_s2      <= score_p2;
        sh_shown   <= sq_shown;
        sh_over    <= game_over;
        sh_startup <= game_startup;
        snap_seen  <= 1'b1;
        frame_cnt  <= frame_cnt + FCNT_W'(1);
      end
    end
  end

  logic [CMP_W-1:0]   x_w, y_w, dx_c, dy_c;
  logic               vis_c, sq_hit_c, pdl_hit_c, net_hit_c, box_c;
  logic [SCORE_W-1:0] glyph_val_c;

  assign x_w = {1'b0, pixel_x};
  assign y_w = {1'b0, pixel_y};

  // Stage 1 geometry: sprite hits and which digit box (if any) holds the pixel.
  always_comb begin
    vis_c       = video_on && snap_seen && (x_w < H_LIM) && (y_w < V_LIM);
    sq_hit_c    = sh_shown && !sh_startup &&
                  in_rect(x_w, y_w, {1'b0, sh_sq_x}, {1'b0, sh_sq_y}, SQ_SZ, SQ_SZ);
    pdl_hit_c   = in_rect(x_w, y_w, {1'b0, sh_p1_x}, {1'b0, sh_p1_y}, PDL_W, PDL_H) ||
                  in_rect(x_w, y_w, {1'b0, sh_p2_x}, {1'b0, sh_p2_y}, PDL_W, PDL_H);
    net_hit_c   = (x_w >= NET_X0) && (x_w < NET_X1) && !pixel_y[4];
    box_c       = 1'b0;
    glyph_val_c = '0;
    dx_c        = '0;
    dy_c        = CMP_W'(y_w - DIG_Y);
    if (!sh_startup) begin
      if (in_rect(x_w, y_w, P1_UX, DIG_Y, BOX_W, BOX_H)) begin
        box_c       = 1'b1;
        glyph_val_c = units_digit(sh_s1);
        dx_c        = CMP_W'(x_w - P1_UX);
      end else if ((sh_s1 >= SCORE_W'(10)) && in_rect(x_w, y_w, P1_TX, DIG_Y, BOX_W, BOX_H)) begin
        box_c       = 1'b1;
        glyph_val_c = SCORE_W'(1);
        dx_c        = CMP_W'(x_w - P1_TX);
      end else if (in_rect(x_w, y_w, P2_UX, DIG_Y, BOX_W, BOX_H)) begin
        box_c       = 1'b1;
        glyph_val_c = units_digit(sh_s2);
        dx_c        = CMP_W'(x_w - P2_UX);
      end else if ((sh_s2 >= SCORE_W'(10)) && in_rect(x_w, y_w, P2_TX, DIG_Y, BOX_W, BOX_H)) begin
        box_c       = 1'b1;
        glyph_val_c = SCORE_W'(1);
        dx_c        = CMP_W'(x_w - P2_TX);
      end
    end
  end

  logic               v1, sq1, pdl1, net1, box1, over1;
  logic [SCORE_W-1:0] val1;
  logic [1:0]         col1;
  logic [2:0]         row1;

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      sq1   <= 1'b0;
      pdl1  <= 1'b0;
      net1  <= 1'b0;
      box1  <= 1'b0;
      over1 <= 1'b0;
      val1  <= '0;
      col1  <= '0;
      row1  <= '0;
    end else begin
      v1    <= vis_c;
      sq1   <= sq_hit_c;
      pdl1  <= pdl_hit_c;
      net1  <= net_hit_c;
      box1  <= box_c;
      over1 <= sh_over;
      val1  <= glyph_val_c;
      col1  <= 2'(dx_c >> CELL_SH);
      row1  <= 3'(dy_c >> CELL_SH);
    end
  end

  logic [GLYPH_W-1:0] font_c;
  logic [3:0]         idx_c;
  logic               score_vis_c;
  logic [RGB_W-1:0]   rgb_c;

  score_glyph u_glyph (
    .digit  (val1),
    .font_c (font_c)
  );

  assign idx_c = 4'(({1'b0, row1} * 4'd3) + {2'b00, col1});

  // Stage 2: font bit, game-over blink, then colour priority.
  always_comb begin
    score_vis_c = box1 && font_c[4'd14 - idx_c] && !(over1 && frame_cnt[5]);
    rgb_c       = COL_BG;
    if (!v1)                 rgb_c = COL_BG;
    else if (sq1 || pdl1)    rgb_c = COL_FG;
    else if (score_vis_c)    rgb_c = over1 ? COL_OVER : COL_FG;
    else if (net1)           rgb_c = COL_NET;
  end

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) pixel_rgb <= COL_BG;
    else     pixel_rgb <= rgb_c;
  end

endmodule

// File: tb/tb_pong_renderer.sv
// Scoreboard bench for pong_renderer: driver queues model-predicted colours,
// a forked monitor pops them two cycles later and compares.
module tb_pong_renderer;

  logic        clk_0 = 1'b0;
  logic        rst   = 1'b1;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        video_on = 1'b0;
  logic [9:0]  sq_xpos = '0, sq_ypos = '0, pdl1_xpos = '0, pdl1_ypos = '0;
  logic [9:0]  pdl2_xpos = '0, pdl2_ypos = '0;
  logic        sq_shown = 1'b0, game_over = 1'b0, game_startup = 1'b0;
  logic [3:0]  score_p1 = '0, score_p2 = '0;
  logic [11:0] pixel_rgb;
  logic        frame_tick;

  pong_renderer dut (
    .clk_0(clk_0), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .sq_xpos(sq_xpos), .sq_ypos(sq_ypos), .pdl1_xpos(pdl1_xpos), .pdl1_ypos(pdl1_ypos),
    .pdl2_xpos(pdl2_xpos), .pdl2_ypos(pdl2_ypos), .sq_shown(sq_shown), .game_over(game_over),
    .game_startup(game_startup), .score_p1(score_p1), .score_p2(score_p2),
    .pixel_rgb(pixel_rgb), .frame_tick(frame_tick)
  );

  always #20 clk_0 = ~clk_0;

  int cyc = 0;
  always @(posedge clk_0) cyc <= cyc + 1;

  typedef struct { int t; int x; int y; logic [11:0] exp; } item_t;
  typedef struct { int t; bit snap; } tick_t;
  item_t rq[$];
  tick_t tq[$];
  int total = 0;
  int bad   = 0;

  // Reference font: rows top to bottom, each row {left, mid, right}.
  bit [2:0] font [0:9][0:4] = '{
    '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
    '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
    '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
    '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
    '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
    '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
    '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
    '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001},
    '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
    '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111}
  };

  // Model shadow of the game state as seen by the renderer.
  int m_sqx, m_sqy, m_p1x, m_p1y, m_p2x, m_p2y, m_s1, m_s2, m_fcnt;
  bit m_shown, m_over, m_startup, m_seen;

  task automatic model_reset();
    m_sqx = 0; m_sqy = 0; m_p1x = 0; m_p1y = 0; m_p2x = 0; m_p2y = 0;
    m_s1 = 0; m_s2 = 0; m_fcnt = 0;
    m_shown = 0; m_over = 0; m_startup = 1; m_seen = 0;
  endtask

  task automatic model_snapshot();
    m_sqx = int'(sq_xpos);   m_sqy = int'(sq_ypos);
    m_p1x = int'(pdl1_xpos); m_p1y = int'(pdl1_ypos);
    m_p2x = int'(pdl2_xpos); m_p2y = int'(pdl2_ypos);
    m_s1 = int'(score_p1);   m_s2 = int'(score_p2);
    m_shown = sq_shown; m_over = game_over; m_startup = game_startup;
    m_fcnt = (m_fcnt + 1) % 64;
    m_seen = 1;
  endtask

  function automatic bit inr(int x, int y, int rx, int ry, int w, int h);
    return x >= rx && x < rx + w && y >= ry && y < ry + h;
  endfunction

  function automatic bit digit_pix(int x, int y, int left, int val);
    int c, r;
    bit [2:0] row_bits;
    if (!inr(x, y, left, 32, 24, 40)) return 0;
    c = (x - left) / 8;
    r = (y - 32) / 8;
    row_bits = font[val][r];
    return row_bits[2 - c];
  endfunction

  function automatic bit score_pix(int x, int y, int s, int ux);
    int u;
    u = (s < 10) ? s : s - 10;
    return digit_pix(x, y, ux, u) || (s >= 10 && digit_pix(x, y, ux - 32, 1));
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, bit von);
    if (!von || !m_seen) return 12'h000;
    if (m_shown && !m_startup && inr(x, y, m_sqx, m_sqy, 16, 16)) return 12'hFFF;
    if (inr(x, y, m_p1x, m_p1y, 12, 96) || inr(x, y, m_p2x, m_p2y, 12, 96)) return 12'hFFF;
    if (!m_startup && (score_pix(x, y, m_s1, 256) || score_pix(x, y, m_s2, 360)) &&
        !(m_over && m_fcnt >= 32))
      return m_over ? 12'hF00 : 12'hFFF;
    if (x >= 318 && x < 322 && ((y / 16) % 2 == 0)) return 12'h888;
    return 12'h000;
  endfunction

  // One pixel per cycle; expectation is either given explicitly or modelled.
  task automatic drive(int x, int y, bit von, bit use_exp, logic [11:0] exp);
    item_t it;
    tick_t tk;
    @(negedge clk_0);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
    it.t = cyc; it.x = x; it.y = y;
    it.exp = use_exp ? exp : model_rgb(x, y, von);
    rq.push_back(it);
    tk.t = cyc; tk.snap = (x == 0 && y == 480);
    tq.push_back(tk);
    if (tk.snap) model_snapshot();
    @(posedge clk_0);
  endtask

  task automatic px(int x, int y, logic [11:0] exp);
    drive(x, y, 1'b1, 1'b1, exp);
  endtask

  task automatic snap();
    drive(0, 480, 1'b0, 1'b1, 12'h000);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (rq.size() != 0 || tq.size() != 0); i++) @(negedge clk_0);
  endtask

  task automatic reset_dut();
    drain();
    @(negedge clk_0);
    video_on = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_0);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic monitor();
    item_t it;
    tick_t tk;
    forever begin
      @(posedge clk_0);
      #1;
      if (rst) begin
        total += 1;
        if (pixel_rgb !== 12'h000 || frame_tick !== 1'b0) begin
          bad += 1;
          $display("FAIL reset_state rgb=%h tick=%b required rgb=000 tick=0", pixel_rgb, frame_tick);
        end
      end else begin
        while (tq.size() != 0 && tq[0].t + 1 <= cyc) begin
          tk = tq.pop_front();
          total += 1;
          if (frame_tick !== tk.snap) begin
            bad += 1;
            $display("FAIL frame_tick t=%0d got %b required %b", tk.t, frame_tick, tk.snap);
          end
        end
        while (rq.size() != 0 && rq[0].t + 2 <= cyc) begin
          it = rq.pop_front();
          total += 1;
          if (pixel_rgb !== it.exp) begin
            bad += 1;
            $display("FAIL rgb t=%0d x=%0d y=%0d got %h required %h", it.t, it.x, it.y, pixel_rgb, it.exp);
          end
        end
      end
    end
  endtask

  task automatic rand_state();
    sq_xpos = 10'($urandom_range(0, 639));  sq_ypos = 10'($urandom_range(0, 479));
    pdl1_xpos = 10'($urandom_range(0, 639)); pdl1_ypos = 10'($urandom_range(0, 479));
    pdl2_xpos = 10'($urandom_range(0, 639)); pdl2_ypos = 10'($urandom_range(0, 479));
    sq_shown = 1'($urandom_range(0, 1));
    game_over = ($urandom_range(0, 3) == 0);
    game_startup = ($urandom_range(0, 3) == 0);
    score_p1 = 4'($urandom_range(0, 15));
    score_p2 = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int x, y;
    model_reset();
    fork
      monitor();
      begin
        #5ms;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk_0);
    rst = 1'b0;

    // Basic frame: square, paddle, scores 7 and 10.
    sq_xpos = 10'd100; sq_ypos = 10'd200; sq_shown = 1'b1; game_startup = 1'b0;
    pdl1_xpos = 10'd24; pdl1_ypos = 10'd192; pdl2_xpos = 10'd600; pdl2_ypos = 10'd100;
    score_p1 = 4'd7; score_p2 = 4'd10;
    px(100, 200, 12'h000);
    px(24, 192, 12'h000);
    snap();
    px(100, 200, 12'hFFF); px(116, 200, 12'h000); px(115, 215, 12'hFFF);
    px(24, 192, 12'hFFF);  px(35, 287, 12'hFFF);  px(36, 192, 12'h000); px(24, 288, 12'h000);
    px(256, 32, 12'hFFF);  px(256, 40, 12'h000);  px(272, 40, 12'hFFF); px(279, 71, 12'hFFF);
    px(280, 32, 12'h000);  px(224, 32, 12'h000);
    px(336, 32, 12'hFFF);  px(328, 32, 12'h000);  px(328, 40, 12'hFFF);
    px(360, 32, 12'hFFF);  px(368, 40, 12'h000);  px(383, 71, 12'hFFF);
    px(319, 0, 12'h888);   px(319, 16, 12'h000);  px(321, 15, 12'h888); px(322, 0, 12'h000);

    // Mid-frame change is deferred to the next snapshot.
    sq_xpos = 10'd300;
    px(100, 200, 12'hFFF); px(300, 200, 12'h000);
    snap();
    px(300, 200, 12'hFFF); px(100, 200, 12'h000);

    // Startup hides square and scores, keeps net and paddles.
    game_startup = 1'b1;
    snap();
    px(300, 200, 12'h000); px(256, 32, 12'h000); px(336, 32, 12'h000);
    px(319, 0, 12'h888);   px(24, 192, 12'hFFF);
    drive(319, 0, 1'b0, 1'b1, 12'h000);

    // Edge clipping without wrap-around.
    game_startup = 1'b0; sq_xpos = 10'd1016; sq_ypos = 10'd1016;
    snap();
    px(4, 4, 12'h000);
    sq_xpos = 10'd630; sq_ypos = 10'd470;
    snap();
    px(639, 479, 12'hFFF); px(630, 470, 12'hFFF); px(5, 470, 12'h000);

    // Back-to-back snapshots each pulse frame_tick.
    snap(); snap();

    // Game-over blink across a frame-counter wrap.
    sq_shown = 1'b0; game_over = 1'b1; score_p1 = 4'd8; score_p2 = 4'd13;
    for (int f = 0; f < 66; f++) begin
      snap();
      drive(256, 32, 1'b1, 1'b0, 12'h000);
      drive(256, 40, 1'b1, 1'b0, 12'h000);
      drive(336, 32, 1'b1, 1'b0, 12'h000);
      px(319, 0, 12'h888);
    end

    // Reset mid-frame blanks everything until the next snapshot.
    game_over = 1'b0; sq_shown = 1'b1; sq_xpos = 10'd100; sq_ypos = 10'd200;
    snap();
    px(100, 200, 12'hFFF);
    reset_dut();
    px(100, 200, 12'h000); px(24, 192, 12'h000); px(319, 0, 12'h000);
    snap();
    px(100, 200, 12'hFFF);

    // Randomized frames against the model, including mid-frame input churn.
    for (int f = 0; f < 8; f++) begin
      rand_state();
      snap();
      for (int i = 0; i < 200; i++) begin
        if (i == 100) rand_state();
        case ($urandom_range(0, 4))
          0: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
          1: begin x = m_sqx + $urandom_range(0, 23) - 4; y = m_sqy + $urandom_range(0, 23) - 4; end
          2: begin x = m_p1x + $urandom_range(0, 19) - 4; y = m_p1y + $urandom_range(0, 103) - 4; end
          3: begin x = $urandom_range(220, 390); y = $urandom_range(28, 76); end
          default: begin x = $urandom_range(314, 325); y = $urandom_range(0, 479); end
        endcase
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        drive(x, y, ($urandom_range(0, 9) != 0), 1'b0, 12'h000);
      end
    end

    drain();
    if (rq.size() != 0 || tq.size() != 0) begin
      bad += 1;
      $display("FAIL drain pending=%0d required 0", rq.size() + tq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
